// File: rtl/sort_pkg.sv
// Shared types and helpers for the sequential bubble-sort controller.
// Holds default sizes, the FSM state encoding and comparison-count helpers.
package sort_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Comparisons in a full bubble sort of n elements.
    function automatic int num_cmp(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Width needed to count 0..num_cmp(n) swaps.
    function automatic int cnt_width(input int n);
        return $clog2(num_cmp(n) + 1);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-and-swap cell shared by every element pair.
// Ports: a, b in; lo/hi ordered out; swap high when a > b (ties keep order).
module cmp_swap #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swap
);

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_ctrl.sv
// Sequential bubble sort of N unsigned W-bit values, one compare per clock.
// Ports: clk, rst_n (async low), start, din[N*W] in; busy, done, dout, swap_cnt out.
// Build option: define SORT_EARLY_EXIT_EN to stop after the first swap-free pass.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [N*W-1:0]                      din,
    output logic                                busy,
    output logic                                done,
    output logic [N*W-1:0]                      dout,
    output logic [$clog2(N*(N-1)/2+1)-1:0]      swap_cnt
);

    localparam int K  = num_cmp(N);
    localparam int CW = cnt_width(N);
    localparam int IW = $clog2(N);

    state_e         state_q, state_d;
    logic [W-1:0]   elem_q [N];
    logic [W-1:0]   elem_d [N];
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  pass_q, pass_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef SORT_EARLY_EXIT_EN
    logic           flg_q, flg_d;
`endif

    logic [IW-1:0]  idx1;
    logic [IW-1:0]  last_idx;
    logic [W-1:0]   cs_lo, cs_hi;
    logic           cs_swap;
    logic           last_cmp;
    logic           last_pass;
    logic           finish;

    assign idx1      = idx_q + IW'(1);
    // Each pass bubbles one more maximum into place, so it ends one slot earlier.
    assign last_idx  = IW'(N - 2) - pass_q;
    assign last_cmp  = (idx_q == last_idx);
    assign last_pass = (pass_q == IW'(N - 2));

    cmp_swap #(.W(W)) u_cmp_swap (
        .a    (elem_q[idx_q]),
        .b    (elem_q[idx1]),
        .lo   (cs_lo),
        .hi   (cs_hi),
        .swap (cs_swap)
    );

`ifdef SORT_EARLY_EXIT_EN
    // A pass with no swaps (this compare included) proves the vector sorted.
    assign finish = last_cmp && (last_pass || !(flg_q || cs_swap));
`else
    assign finish = last_cmp && last_pass;
`endif

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        flg_d   = flg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < N; k++) begin
                        elem_d[k] = din[k*W +: W];
                    end
                    cnt_d   = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SORT;
`ifdef SORT_EARLY_EXIT_EN
                    flg_d   = 1'b0;
`endif
                end
            end
            SORT: begin
                busy_d        = 1'b1;
                elem_d[idx_q] = cs_lo;
                elem_d[idx1]  = cs_hi;
                if (cs_swap) begin
                    cnt_d = cnt_q + CW'(1);
                end
`ifdef SORT_EARLY_EXIT_EN
                flg_d = flg_q | cs_swap;
`endif
                if (finish) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (!last_cmp) begin
                    idx_d = idx1;
                end else begin
                    pass_d = pass_q + IW'(1);
                    idx_d  = '0;
`ifdef SORT_EARLY_EXIT_EN
                    flg_d  = 1'b0;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int k = 0; k < N; k++) begin
                elem_q[k] <= '0;
            end
            idx_q   <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            flg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SORT_EARLY_EXIT_EN
            flg_q   <= flg_d;
`endif
        end
    end

    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            dout[k*W +: W] = elem_q[k];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign swap_cnt = cnt_q;

    // K is kept for readers sizing swap_cnt; it equals the full-sort compare count.
    logic unused_k;
    assign unused_k = (K == 0);

endmodule
